// File: rtl/ccd_bridge_if.sv
`default_nettype none
// ============================================================================
// ccd_bridge_if : core-side and slow-side memory signals of the ccd_bridge
// Revision      : 1.0
// ============================================================================
interface ccd_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    memory_valid;
    logic                    memory_instr;
    logic [ADDR_WIDTH-1:0]   memory_addr;
    logic [DATA_WIDTH-1:0]   memory_wdata;
    logic [DATA_WIDTH/8-1:0] memory_wstrb;
    logic [DATA_WIDTH-1:0]   memory_rdata;
    logic                    memory_ready;
    logic                    memory_error;
    logic                    memory_full;
    logic                    memory_overflow;
    logic                    memory_slow_valid;
    logic                    memory_slow_instr;
    logic [ADDR_WIDTH-1:0]   memory_slow_addr;
    logic [DATA_WIDTH-1:0]   memory_slow_wdata;
    logic [DATA_WIDTH/8-1:0] memory_slow_wstrb;
    logic [DATA_WIDTH-1:0]   memory_slow_rdata;
    logic                    memory_slow_ready;

    // Environment view: the core arbiter plus the slow device.
    modport master (
        output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
        output memory_slow_rdata, memory_slow_ready,
        input  memory_rdata, memory_ready, memory_error, memory_full, memory_overflow,
        input  memory_slow_valid, memory_slow_instr, memory_slow_addr,
        input  memory_slow_wdata, memory_slow_wstrb
    );

    // Bridge view.
    modport slave (
        input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
        input  memory_slow_rdata, memory_slow_ready,
        output memory_rdata, memory_ready, memory_error, memory_full, memory_overflow,
        output memory_slow_valid, memory_slow_instr, memory_slow_addr,
        output memory_slow_wdata, memory_slow_wstrb
    );
endinterface
`default_nettype wire

// File: rtl/ccd_bridge.sv
`default_nettype none
// ============================================================================
// ccd_bridge : posted-request bridge from the fast core port to a slow port
//              strobed every RATIO cycles, with request FIFO and timeout
// Revision   : 1.0
// ============================================================================
module ccd_bridge #(
    parameter int RATIO      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 0
) (
    input  wire logic   clock,
    input  wire logic   reset,
    ccd_bridge_if.slave mem
);
    localparam int c_strb_w = DATA_WIDTH / 8;
    localparam int c_cnt_w  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int c_idx_w  = $clog2(DEPTH);
    localparam int c_ptr_w  = c_idx_w + 1;
    localparam int c_tmo_w  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_last_count = c_cnt_w'(RATIO - 1);

    typedef struct packed {
        logic                  instr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [c_strb_w-1:0]   wstrb;
    } req_t;

    req_t                  r_fifo [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic                  r_overflow;
    logic                  r_ready;
    logic                  r_error;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic w_tick;
    logic w_empty;
    logic w_full_occ;
    logic w_done;
    logic w_abort;
    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_drop;
    req_t w_head;

    always_comb begin
        w_tick     = (r_count == c_last_count);
        w_empty    = (r_wr_ptr == r_rd_ptr);
        w_full_occ = (r_wr_ptr[c_ptr_w-1] != r_rd_ptr[c_ptr_w-1]) &&
                     (r_wr_ptr[c_idx_w-1:0] == r_rd_ptr[c_idx_w-1:0]);
        w_done     = w_tick && !w_empty && mem.memory_slow_ready;
        w_pop      = w_done || w_abort;
        // A same-cycle pop frees the slot, so the core only sees "full" when
        // nothing leaves this cycle.
        w_full     = w_full_occ && !w_pop;
        w_push     = mem.memory_valid && !w_full;
        w_drop     = mem.memory_valid && w_full;
        w_head     = r_fifo[r_rd_ptr[c_idx_w-1:0]];
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
            logic [c_tmo_w-1:0] r_tmo_cnt;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_tmo_cnt <= '0;
                end else if (w_pop || (w_push && w_empty)) begin
                    r_tmo_cnt <= '0;
                end else if (w_tick && !w_empty) begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end

            // Ready on the final tick takes priority over the abort.
            assign w_abort = w_tick && !w_empty && !mem.memory_slow_ready &&
                             (r_tmo_cnt == c_tmo_last);
        end else begin : g_no_timeout
            assign w_abort = 1'b0;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[c_idx_w-1:0]] <= '{instr: mem.memory_instr,
                                               addr:  mem.memory_addr,
                                               wdata: mem.memory_wdata,
                                               wstrb: mem.memory_wstrb};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_count <= w_tick ? '0 : r_count + 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_ready <= w_pop;
            r_error <= w_abort;
            r_rdata <= w_done ? mem.memory_slow_rdata : '0;
        end
    end

    assign mem.memory_rdata      = r_rdata;
    assign mem.memory_ready      = r_ready;
    assign mem.memory_error      = r_error;
    assign mem.memory_full       = w_full;
    assign mem.memory_overflow   = r_overflow;
    assign mem.memory_slow_valid = !w_empty;
    assign mem.memory_slow_instr = w_empty ? 1'b0 : w_head.instr;
    assign mem.memory_slow_addr  = w_empty ? '0   : w_head.addr;
    assign mem.memory_slow_wdata = w_empty ? '0   : w_head.wdata;
    assign mem.memory_slow_wstrb = w_empty ? '0   : w_head.wstrb;
endmodule
`default_nettype wire
